// File: rtl/noc_rr_arbiter.sv
// Round-robin packet arbiter for a NoC router output port; grant is held from first flit to last flit.
// Optional per-port packet counters (pkt_count) are built when NOC_ARB_STATS_EN is defined.
module noc_rr_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned ID_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            in_valid,
  output logic [NUM_PORTS-1:0]            in_ready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_last,
  output logic [NUM_PORTS-1:0]            out_grant,
`ifdef NOC_ARB_STATS_EN
  output logic [ID_WIDTH-1:0]             out_port_id,
  output logic [NUM_PORTS*16-1:0]         pkt_count
`else
  output logic [ID_WIDTH-1:0]             out_port_id
`endif
);

  localparam int LAST_IDX = int'(NUM_PORTS) - 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state;
  logic [ID_WIDTH-1:0]   ptr;
  logic [ID_WIDTH-1:0]   lock_id;
  logic [ID_WIDTH-1:0]   gnt_id;
  logic                  gnt_hit;
  logic                  hs;

  function automatic logic [ID_WIDTH-1:0] inc_wrap(input logic [ID_WIDTH-1:0] v);
    if (int'(v) >= LAST_IDX) return '0;
    return v + ID_WIDTH'(1);
  endfunction

  // Grant select: rotating search from ptr when idle, fixed lock_id while a packet is in flight.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_id  = '0;
    gnt_hit = 1'b0;
    if (state == LOCKED) begin
      gnt_id  = lock_id;
      gnt_hit = 1'b1;
    end else begin
      for (int k = 0; k < int'(NUM_PORTS); k++) begin
        idx = int'(ptr) + k;
        if (idx >= int'(NUM_PORTS)) idx = idx - int'(NUM_PORTS);
        if (!gnt_hit && in_valid[idx]) begin
          gnt_hit = 1'b1;
          gnt_id  = ID_WIDTH'(idx);
        end
      end
    end
    if (rst) begin
      gnt_hit = 1'b0;
      gnt_id  = '0;
    end
  end

  // Output mux; everything is forced to zero while no grant exists.
  always_comb begin
    out_grant   = '0;
    out_data    = '0;
    out_last    = 1'b0;
    out_port_id = gnt_hit ? gnt_id : '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      out_grant[i] = gnt_hit && (gnt_id == ID_WIDTH'(i));
      if (out_grant[i]) begin
        out_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        out_last = in_last[i];
      end
    end
    out_valid = |(out_grant & in_valid);
    in_ready  = out_grant & {NUM_PORTS{out_ready}};
    hs        = out_valid & out_ready;
  end

  // Lock on any offered flit that is not a completed last flit, so a stalled flit cannot be re-arbitrated.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      lock_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (out_valid) begin
            if (out_ready && out_last) begin
              ptr <= inc_wrap(gnt_id);
            end else begin
              state   <= LOCKED;
              lock_id <= gnt_id;
            end
          end
        end
        LOCKED: begin
          if (hs && out_last) begin
            state <= IDLE;
            ptr   <= inc_wrap(lock_id);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef NOC_ARB_STATS_EN
  // Per-port completed-packet counters, free-running with natural 16-bit wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_PORTS); i++) begin
        if (hs && out_last && out_grant[i]) begin
          pkt_count[i*16 +: 16] <= pkt_count[i*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Directed self-checking bench for noc_rr_arbiter (NUM_PORTS=4, DATA_WIDTH=32).
// Inputs change just after the falling edge; outputs are sampled 1 ns later, clear of the rising edge.
module tb_noc_rr_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     in_valid;
  logic [NP-1:0]     in_ready;
  logic [NP*DW-1:0]  in_data;
  logic [NP-1:0]     in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic [NP-1:0]     out_grant;
  logic [1:0]        out_port_id;
`ifdef NOC_ARB_STATS_EN
  logic [NP*16-1:0]  pkt_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  noc_rr_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_grant   (out_grant),
`ifdef NOC_ARB_STATS_EN
    .out_port_id (out_port_id),
    .pkt_count   (pkt_count)
`else
    .out_port_id (out_port_id)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int i, input logic v, input logic [DW-1:0] d, input logic l);
    in_valid[i]          = v;
    in_data[i*DW +: DW]  = d;
    in_last[i]           = l;
  endtask

  // Check a cycle where port id is granted with the given flit visible on the output.
  task automatic check_grant(input string tag, input int id, input logic v,
                             input logic [DW-1:0] d, input logic l);
    logic [NP-1:0] oh;
    oh = NP'(1) << id;
    check({tag, ".grant"}, 64'(out_grant), 64'(oh));
    check({tag, ".id"},    64'(out_port_id), 64'(id));
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    check({tag, ".ready"}, 64'(in_ready), 64'(out_ready ? oh : '0));
    if (v) begin
      check({tag, ".data"}, 64'(out_data), 64'(d));
      check({tag, ".last"}, 64'(out_last), 64'(l));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, 64'(out_valid), 64'd0);
    check({tag, ".ready"}, 64'(in_ready), 64'd0);
    check({tag, ".grant"}, 64'(out_grant), 64'd0);
    check({tag, ".id"},    64'(out_port_id), 64'd0);
    check({tag, ".data"},  64'(out_data), 64'd0);
    check({tag, ".last"},  64'(out_last), 64'd0);
  endtask

  task automatic clear_inputs();
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();

    // Outputs held at zero during reset even with every input requesting.
    @(negedge clk);
    in_valid = '1; in_last = '1; out_ready = 1'b1; in_data = '1;
    #1 check_zero("rst_hold");
    @(negedge clk);
    rst = 1'b0;

    // Single-flit packets from all ports rotate 0,1,2,3,0.
    for (int i = 0; i < 4; i++) set_port(i, 1'b1, 32'h100 + 32'(i), 1'b1);
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      int exp_id;
      exp_id = c % 4;
      #1 check_grant($sformatf("rr%0d", c), exp_id, 1'b1, 32'h100 + 32'(exp_id), 1'b1);
      @(negedge clk);
    end

    // Port 2 three-flit packet is not interleaved with port 0 singles.
    do_reset();
    out_ready = 1'b1;
    set_port(0, 1'b1, 32'h10, 1'b1);
    set_port(2, 1'b1, 32'hA0, 1'b0);
    #1 check_grant("pk0", 0, 1'b1, 32'h10, 1'b1);
    @(negedge clk);
    #1 check_grant("pk1", 2, 1'b1, 32'hA0, 1'b0);
    @(negedge clk);
    set_port(2, 1'b1, 32'hA1, 1'b0);
    #1 check_grant("pk2", 2, 1'b1, 32'hA1, 1'b0);
    check("pk2.rdy0", 64'(in_ready[0]), 64'd0);
    @(negedge clk);
    set_port(2, 1'b1, 32'hA2, 1'b1);
    #1 check_grant("pk3", 2, 1'b1, 32'hA2, 1'b1);
    @(negedge clk);
    // ptr is now 3: with ports 0 and 2 both valid the search 3,0 picks port 0.
    set_port(2, 1'b1, 32'hB0, 1'b1);
    #1 check_grant("pk4", 0, 1'b1, 32'h10, 1'b1);

    // Backpressure freezes the grant on port 1 even after port 0 appears.
    do_reset();
    out_ready = 1'b0;
    set_port(1, 1'b1, 32'h55, 1'b1);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) set_port(0, 1'b1, 32'h66, 1'b1);
      #1 check_grant($sformatf("bp%0d", c), 1, 1'b1, 32'h55, 1'b1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check_grant("bp_acc", 1, 1'b1, 32'h55, 1'b1);
    @(negedge clk);
    set_port(1, 1'b0, 32'h0, 1'b0);
    #1 check_grant("bp_next", 0, 1'b1, 32'h66, 1'b1);

    // Locked port 3 bubbles for two cycles; grant held, then port 1 next.
    do_reset();
    out_ready = 1'b1;
    set_port(3, 1'b1, 32'hC0, 1'b0);
    #1 check_grant("bub0", 3, 1'b1, 32'hC0, 1'b0);
    @(negedge clk);
    set_port(3, 1'b0, 32'hC0, 1'b0);
    set_port(1, 1'b1, 32'h11, 1'b1);
    for (int c = 1; c < 3; c++) begin
      #1 check_grant($sformatf("bub%0d", c), 3, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
    end
    set_port(3, 1'b1, 32'hC1, 1'b1);
    #1 check_grant("bub3", 3, 1'b1, 32'hC1, 1'b1);
    @(negedge clk);
    set_port(3, 1'b1, 32'hD0, 1'b1);
    #1 check_grant("bub4", 1, 1'b1, 32'h11, 1'b1);

    // Reset while locked on port 2 abandons the packet and restarts from port 0.
    do_reset();
    out_ready = 1'b1;
    set_port(2, 1'b1, 32'hE0, 1'b0);
    #1 check_grant("rl0", 2, 1'b1, 32'hE0, 1'b0);
    @(negedge clk);
    set_port(0, 1'b1, 32'h20, 1'b1);
    set_port(2, 1'b1, 32'hE1, 1'b0);
    #1 check_grant("rl1", 2, 1'b1, 32'hE1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1 check_zero("rl_rst");
    @(negedge clk);
    rst = 1'b0;
    #1 check_grant("rl2", 0, 1'b1, 32'h20, 1'b1);
`ifdef NOC_ARB_STATS_EN
    check("rl_cnt", 64'(pkt_count), 64'd0);
`endif

`ifdef NOC_ARB_STATS_EN
    // 70000 single-flit packets from port 1: counter wraps to 70000 mod 65536.
    do_reset();
    out_ready = 1'b1;
    set_port(1, 1'b1, 32'h77, 1'b1);
    repeat (70000) @(negedge clk);
    in_valid = '0;
    #1;
    check("cnt1", 64'(pkt_count[31:16]), 64'd4464);
    check("cnt0", 64'(pkt_count[15:0]), 64'd0);
    check("cnt2", 64'(pkt_count[47:32]), 64'd0);
    check("cnt3", 64'(pkt_count[63:48]), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
